// File: rtl/mux_sel_arb_pkg.sv
// Shared types and constants for the mux_sel_arbiter slice: owner states,
// mux2x1 select encoding and the width of the optional beat counters.
package mux_sel_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic SEL_A  = 1'b0;
  localparam logic SEL_B  = 1'b1;
  localparam int   STAT_W = 16;

endpackage

// File: rtl/mux2x1.sv
// Single-bit 2:1 mux; sel=0 passes a, sel=1 passes b.
module mux2x1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin, burst-limited arbiter for two valid/ready streams feeding a
// registered 2:1 mux stage. Define MUX_SEL_ARBITER_STATS_EN for per-stream beat counters.
module mux_sel_arbiter
  import mux_sel_arb_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_a_valid,
  output logic              in_a_ready,
  input  logic [DATA_W-1:0] in_a_data,
  input  logic              in_b_valid,
  output logic              in_b_ready,
  input  logic [DATA_W-1:0] in_b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sel
`ifdef MUX_SEL_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_a_cnt,
  output logic [STAT_W-1:0] stat_b_cnt
`endif
);

  localparam int                CNT_W   = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  state_t              r_state;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic                r_last_owner;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_sel;

  logic                w_any;
  logic                w_free;
  logic                w_load;
  logic                w_at_limit;
  logic                w_win;
  state_t              w_win_state;
  logic [DATA_W-1:0]   w_mux_data;

  assign w_any      = in_a_valid | in_b_valid;
  assign w_free     = !r_out_valid | out_ready;
  assign w_load     = !rst & w_free & w_any;
  assign w_at_limit = (r_burst_cnt == BURST_C);

  // The owner keeps the grant until its burst is spent and the other side is waiting.
  always_comb begin
    w_win = SEL_A;
    case (r_state)
      OWN_A:   w_win = (in_a_valid && (!w_at_limit || !in_b_valid)) ? SEL_A : SEL_B;
      OWN_B:   w_win = (in_b_valid && (!w_at_limit || !in_a_valid)) ? SEL_B : SEL_A;
      default: begin
        if (in_a_valid && !in_b_valid)      w_win = SEL_A;
        else if (in_b_valid && !in_a_valid) w_win = SEL_B;
        else                                w_win = !r_last_owner;
      end
    endcase
  end

  assign w_win_state = (w_win == SEL_B) ? OWN_B : OWN_A;
  assign in_a_ready  = w_load & (w_win == SEL_A);
  assign in_b_ready  = w_load & (w_win == SEL_B);

  for (genvar i = 0; i < DATA_W; i++) begin : g_mux
    mux2x1 u_mux (
      .a   (in_a_data[i]),
      .b   (in_b_data[i]),
      .sel (w_win),
      .y   (w_mux_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_burst_cnt  <= '0;
      r_last_owner <= SEL_B;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_sel    <= SEL_A;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_sel   <= w_win;
      if (r_state == w_win_state) begin
        r_burst_cnt <= w_at_limit ? r_burst_cnt : r_burst_cnt + CNT_W'(1);
      end else begin
        r_burst_cnt  <= CNT_W'(1);
        r_state      <= w_win_state;
        r_last_owner <= w_win;
      end
    end else begin
      if (out_ready) r_out_valid <= 1'b0;
      if (w_free && !w_any) begin
        r_state     <= IDLE;
        r_burst_cnt <= '0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

`ifdef MUX_SEL_ARBITER_STATS_EN
  logic [STAT_W-1:0] r_stat_a;
  logic [STAT_W-1:0] r_stat_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_a <= '0;
      r_stat_b <= '0;
    end else begin
      if (in_a_ready && (r_stat_a != '1)) r_stat_a <= r_stat_a + STAT_W'(1);
      if (in_b_ready && (r_stat_b != '1)) r_stat_b <= r_stat_b + STAT_W'(1);
    end
  end

  assign stat_a_cnt = r_stat_a;
  assign stat_b_cnt = r_stat_b;
`endif

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: one instance with BURST=4 and one with
// BURST=1 share the same input stimulus; outputs are checked against hand-derived values.
module tb_mux_sel_arbiter;
  import mux_sel_arb_pkg::*;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid, out_ready;
  logic [7:0] a_data, b_data;

  logic       o4_a_ready, o4_b_ready, o4_valid, o4_sel;
  logic [7:0] o4_data;
  logic       o1_a_ready, o1_b_ready, o1_valid, o1_sel;
  logic [7:0] o1_data;
`ifdef MUX_SEL_ARBITER_STATS_EN
  logic [STAT_W-1:0] s4_a, s4_b, s1_a, s1_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mux_sel_arbiter #(.DATA_W(8), .BURST(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_a_valid(a_valid), .in_a_ready(o4_a_ready), .in_a_data(a_data),
    .in_b_valid(b_valid), .in_b_ready(o4_b_ready), .in_b_data(b_data),
    .out_valid(o4_valid), .out_ready(out_ready), .out_data(o4_data), .out_sel(o4_sel)
`ifdef MUX_SEL_ARBITER_STATS_EN
    , .stat_a_cnt(s4_a), .stat_b_cnt(s4_b)
`endif
  );

  mux_sel_arbiter #(.DATA_W(8), .BURST(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_a_valid(a_valid), .in_a_ready(o1_a_ready), .in_a_data(a_data),
    .in_b_valid(b_valid), .in_b_ready(o1_b_ready), .in_b_data(b_data),
    .out_valid(o1_valid), .out_ready(out_ready), .out_data(o1_data), .out_sel(o1_sel)
`ifdef MUX_SEL_ARBITER_STATS_EN
    , .stat_a_cnt(s1_a), .stat_b_cnt(s1_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    a_data = 8'h10; b_data = 8'h00;
    step(); step();
    check("rst_a_ready", 32'(o4_a_ready), 32'h0);
    check("rst_b_ready", 32'(o4_b_ready), 32'h0);
    check("rst_valid",   32'(o4_valid),   32'h0);
    check("rst_data",    32'(o4_data),    32'h0);
    check("rst_sel",     32'(o4_sel),     32'h0);

    // A only: ten back-to-back beats
    b_valid = 1'b0; rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      a_data = 8'(8'h10 + k);
      #1;
      check("t1_a_ready", 32'(o4_a_ready), 32'h1);
      check("t1_b_ready", 32'(o4_b_ready), 32'h0);
      step();
      check("t1_valid", 32'(o4_valid), 32'h1);
      check("t1_data",  32'(o4_data),  32'(8'h10 + k));
      check("t1_sel",   32'(o4_sel),   32'h0);
    end
    a_valid = 1'b0;
    step();
    check("t1_drain", 32'(o4_valid), 32'h0);

    rst = 1'b1;
    step();
    rst = 1'b0;

    // Both valid from reset: BURST=4 bursts and BURST=1 alternation
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'hAA; b_data = 8'hBB;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_valid", 32'(o4_valid), 32'h1);
      check("t2_sel",   32'(o4_sel),   32'((i / 4) % 2));
      check("t2_data",  32'(o4_data),  (((i / 4) % 2) == 1) ? 32'hBB : 32'hAA);
      check("t3_valid", 32'(o1_valid), 32'h1);
      check("t3_sel",   32'(o1_sel),   32'(i % 2));
    end

    // Output stall mid-burst
    out_ready = 1'b0;
    #1;
    check("t4_a_ready", 32'(o4_a_ready), 32'h0);
    check("t4_b_ready", 32'(o4_b_ready), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t4_hold_valid", 32'(o4_valid), 32'h1);
      check("t4_hold_sel",   32'(o4_sel),   32'h0);
      check("t4_hold_data",  32'(o4_data),  32'hAA);
      check("t4_hold_sel1",  32'(o1_sel),   32'h1);
    end
    out_ready = 1'b1;
    #1;
    check("t4_load_ready", 32'(o4_a_ready), 32'h1);
    for (int j = 0; j < 3; j++) begin
      step();
      check("t4_resume_sel",  32'(o4_sel), (j == 2) ? 32'h1 : 32'h0);
      check("t4_resume_sel1", 32'(o1_sel), 32'(j % 2));
    end

    // Reset while holding a B beat
    rst = 1'b1;
    #1;
    check("t5_a_ready", 32'(o4_a_ready), 32'h0);
    check("t5_b_ready", 32'(o4_b_ready), 32'h0);
    step();
    check("t5_valid", 32'(o4_valid), 32'h0);
    rst = 1'b0;
    step();
    check("t5_sel",  32'(o4_sel),  32'h0);
    check("t5_data", 32'(o4_data), 32'hAA);
    check("t5_sel1", 32'(o1_sel),  32'h0);

    // Idle gap keeps last_owner=A, so the next contest goes to B
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("idle_valid", 32'(o4_valid), 32'h0);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("idle_b_ready", 32'(o4_b_ready), 32'h1);
    check("idle_a_ready", 32'(o4_a_ready), 32'h0);
    step();
    check("idle_sel",  32'(o4_sel),  32'h1);
    check("idle_data", 32'(o4_data), 32'hBB);

`ifdef MUX_SEL_ARBITER_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b0; out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check("t6_stat_a", 32'(s4_a), 32'hFFFF);
    check("t6_stat_b", 32'(s4_b), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
